ps2_host_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hF4, 8'hED) to a keyboard or mouse.

---
 rtl/ps2_host_transmitter_pkg.sv | 25 ++
 rtl/ps2_host_transmitter_line_filter.sv | 38 +++
 rtl/ps2_host_transmitter.sv | 154 +++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_transmitter_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing constants, command bytes.
package ps2_host_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_RELEASE
  } tx_state_t;

  localparam int DEF_INHIBIT_CYCLES = 12000;
  localparam int DEF_TIMEOUT_CYCLES = 1500000;
  localparam int DEF_FILTER_LEN     = 8;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_transmitter_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus agreement filter for one PS/2 line, with falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic filt,
  output logic fall
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  filt_q;
  logic                  filt_prev_q;

  // Idle bus level is high, so everything resets to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], line_in};
      hist_q      <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      filt_prev_q <= filt_q;
      if (&hist_q)
        filt_q <= 1'b1;
      else if (~|hist_q)
        filt_q <= 1'b0;
    end
  end

  assign filt = filt_q;
  assign fall = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device, ACK check, watchdog.
//
// state   | meaning
// IDLE    | lines released, waiting for wr_ps2
// RTS     | ps2c held low for the inhibit time
// START   | ps2c released, start bit (data low) driven
// DATA    | d0..d7 and parity presented on each device fall
// STOP    | data released (stop bit), ACK sampled on 11th fall
// RELEASE | waiting for device to release both lines
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       sh_q, sh_d;
  logic [3:0]       n_q, n_d;
  logic             ack_err_q, ack_err_d;
  logic             c_filt, c_fall, d_filt, d_fall_unused;
  logic             wd_active;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk(clk), .reset(reset), .line_in(ps2c_in), .filt(c_filt), .fall(c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk(clk), .reset(reset), .line_in(ps2d_in), .filt(d_filt), .fall(d_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      n_q       <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      n_q       <= n_d;
      ack_err_q <= ack_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    n_d          = n_q;
    ack_err_d    = ack_err_q;
    ps2c_oe      = 1'b0;
    ps2d_oe      = 1'b0;
    tx_idle      = 1'b0;
    tx_done_tick = 1'b0;
    timeout_err  = 1'b0;
    wd_active    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_idle = 1'b1;
        if (wr_ps2) begin
          sh_d      = {odd_parity(din), din};
          ack_err_d = 1'b0;
          cnt_d     = INHIBIT_LOAD;
          state_d   = ST_RTS;
        end
      end
      ST_RTS: begin
        ps2c_oe = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = TIMEOUT_LOAD;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_START: begin
        wd_active = 1'b1;
        ps2d_oe   = 1'b1;
        if (c_fall) begin
          n_d     = 4'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        wd_active = 1'b1;
        ps2d_oe   = ~sh_q[0];
        if (c_fall) begin
          if (n_q < 4'd8) begin
            sh_d = {1'b0, sh_q[8:1]};
            n_d  = n_q + 4'd1;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        wd_active = 1'b1;
        if (c_fall) begin
          ack_err_d = d_filt;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        wd_active = 1'b1;
        if (c_filt && d_filt) begin
          tx_done_tick = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fall in the expiry cycle reloads the watchdog instead of aborting.
    if (wd_active) begin
      if (c_fall) begin
        cnt_d = TIMEOUT_LOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (!tx_done_tick) begin
        ps2c_oe     = 1'b0;
        ps2d_oe     = 1'b0;
        timeout_err = 1'b1;
        state_d     = ST_IDLE;
      end
    end
  end

  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: reset/strobe vector table plus an open-drain PS/2 device model.
module tb_ps2_host_transmitter;

  localparam int INHIBIT = 200;
  localparam int TIMEOUT = 20000;
  localparam int FLEN    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_err;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(FLEN)
  ) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Wired-AND open-drain bus with pull-up
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  int  checks = 0;
  int  errors = 0;
  int  coe_cycles = 0;
  int  done_cnt = 0;
  int  to_cnt = 0;
  bit  busy = 1'b0;
  bit  idle_bad = 1'b0;
  time rel_time = 0;
  time done_time = 0;

  always @(negedge clk) begin
    if (ps2c_oe === 1'b1) coe_cycles++;
    if (busy && tx_idle !== 1'b0) idle_bad = 1'b1;
    if (tx_done_tick === 1'b1) begin
      done_cnt++;
      done_time = $time;
      busy = 1'b0;
    end
    if (timeout_err === 1'b1) begin
      to_cnt++;
      busy = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    @(negedge clk);
    coe_cycles = 0;
    wr_ps2 = 1'b1;
    din = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
    busy = 1'b1;
  endtask

  // Device: waits for start condition, clocks 11 bits, samples data on rising edges.
  task automatic dev_frame(input bit do_ack, input bit glitch, output logic [10:0] bits, output bit ok);
    ok = 1'b0;
    bits = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ps2c_in === 1'b1 && ps2d_in === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    for (int k = 0; k < 11; k++) begin
      repeat (50) @(negedge clk);
      dev_c_low = 1'b1;
      repeat (50) @(negedge clk);
      dev_c_low = 1'b0;
      if (k < 10) bits[k] = ps2d_in;
      if (k == 9 && do_ack) dev_d_low = 1'b1;
      if (k == 10) begin
        dev_d_low = 1'b0;
        rel_time = $time;
      end
      if (glitch && k == 3) begin
        repeat (20) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (FLEN - 1) @(negedge clk);
        dev_c_low = 1'b0;
      end
    end
  endtask

  task automatic frame_body(input string tag, input logic [7:0] exp_byte, input logic exp_par,
                            input bit do_ack, input bit glitch);
    logic [10:0] bits;
    bit ok;
    int d0;
    int lat;
    d0 = done_cnt;
    dev_frame(do_ack, glitch, bits, ok);
    check({tag, "_start_seen"}, 32'(ok), 32'd1);
    check({tag, "_data"}, 32'(bits[7:0]), 32'(exp_byte));
    check({tag, "_parity"}, 32'(bits[8]), 32'(exp_par));
    check({tag, "_stop"}, 32'(bits[9]), 32'd1);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check({tag, "_done_ticks"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_ack_err"}, 32'(ack_err), 32'(!do_ack));
    lat = int'((done_time - rel_time) / 10);
    check({tag, "_release_latency_ok"}, 32'(lat > 0 && lat <= FLEN + 3), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic [5:0] exp;  // {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_err}
  } vec_t;

  vec_t        vecs[10];
  logic [10:0] bits_x;
  bit          ok_x;
  int          n, d0, t0, found;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 6'b001000};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 6'b001000};
    vecs[2] = '{1'b0, 1'b1, 8'hED, 6'b100000};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 6'b100000};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 6'b100000};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 6'b001000};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 6'b001000};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 6'b100000};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 6'b001000};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 6'b001000};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      wr_ps2 = vecs[i].wr;
      din = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_outputs", i),
            32'({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_err}), 32'(vecs[i].exp));
    end
    wr_ps2 = 1'b0;
    repeat (20) @(negedge clk);

    // ED with ACK
    idle_bad = 1'b0;
    do_write(8'hED);
    frame_body("s1_ED", 8'hED, 1'b1, 1'b1, 1'b0);
    check("s1_rts_cycles", 32'(coe_cycles), 32'(INHIBIT));
    check("s1_tx_idle_low_in_frame", 32'(idle_bad), 32'd0);

    // 00 without ACK
    do_write(8'h00);
    frame_body("s3_00", 8'h00, 1'b1, 1'b0, 1'b0);

    // F4: the accepting write clears ack_err
    do_write(8'hF4);
    check("s2_ack_err_cleared", 32'(ack_err), 32'd0);
    frame_body("s2_F4", 8'hF4, 1'b0, 1'b1, 1'b0);
    check("s2_rts_cycles", 32'(coe_cycles), 32'(INHIBIT));

    // Device never clocks: watchdog
    d0 = done_cnt;
    t0 = to_cnt;
    do_write(8'hF4);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ps2d_oe === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("s4_start_reached", 32'(found), 32'd1);
    n = 1;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err === 1'b1) break;
    end
    check("s4_timeout_cycle", 32'(n), 32'(TIMEOUT));
    check("s4_oe_released", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    @(negedge clk);
    check("s4_idle_after_abort", 32'({tx_idle, timeout_err}), 32'b10);
    repeat (5) @(negedge clk);
    check("s4_timeout_pulses", 32'(to_cnt - t0), 32'd1);
    check("s4_no_done_tick", 32'(done_cnt - d0), 32'd0);
    check("s4_ack_err_unchanged", 32'(ack_err), 32'd0);

    // wr_ps2 mid-DATA is ignored
    do_write(8'h5A);
    fork
      frame_body("s5_5A", 8'h5A, 1'b1, 1'b1, 1'b0);
      begin
        repeat (450) @(negedge clk);
        wr_ps2 = 1'b1;
        din = 8'hFF;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join

    // Reset mid-DATA
    do_write(8'hED);
    fork
      dev_frame(1'b1, 1'b0, bits_x, ok_x);
      begin
        repeat (450) @(negedge clk);
        check("s5_busy_before_reset", 32'(tx_idle), 32'd0);
        reset = 1'b1;
        busy = 1'b0;
        @(negedge clk);
        check("s5_reset_releases", 32'({ps2c_oe, ps2d_oe, tx_idle}), 32'b001);
        reset = 1'b0;
      end
    join
    repeat (50) @(negedge clk);

    // Short clock glitch inside DATA
    do_write(8'h3C);
    frame_body("s6_glitch", 8'h3C, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1);
  end

endmodule
